encoder16to4_seq_low_enable: RTL
================================

ENCODER16TO4_SEQ_LOW_ENABLE -- requirements
Module: encoder16to4_seq_low_enable

Interface
REQ-001 SHALL have parameter LSB_FIRST, default 1: 1 = lowest set index served first, 0 = highest set index first.
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port e, input, 1 bit: enable, active-low (0 = enabled).
REQ-005 SHALL have port load, input, 1 bit: capture request vector this cycle.
REQ-006 SHALL have port w, input, 16 bits: request vector, multi-hot allowed.
REQ-007 SHALL have port y_ready, input, 1 bit: consumer accepts current code.
REQ-008 SHALL have port y, output, 4 bits: encoded index of bit being served.
REQ-009 SHALL have port y_valid, output, 1 bit: y holds a valid code.
REQ-010 SHALL have port busy, output, 1 bit: frame in progress (state not IDLE).
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse at end of non-empty frame.
REQ-012 SHALL have port zero, output, 1 bit: one-cycle pulse when captured vector is all zeros.
REQ-013 SHALL have port count, output, 5 bits: codes accepted in current/last frame (0-16).

Function
REQ-014 SHALL implement states IDLE, EMIT, DONE with a 16-bit pending register pend.
REQ-015 IDLE: if load=1 and e=0 at a rising edge, SHALL capture pend<=w and clear count to 0.
REQ-016 IDLE capture of w=0 SHALL stay in IDLE and assert zero for exactly the following cycle; done not asserted.
REQ-017 IDLE capture of w!=0 SHALL go to EMIT; y_valid high in the cycle after the capture edge (latency 1).
REQ-018 load with e=1, or load while busy, SHALL be ignored (pend unchanged, no pulse).
REQ-019 EMIT: y SHALL be index of lowest set bit of pend (LSB_FIRST=1) or highest set bit (LSB_FIRST=0), derived from registered pend only.
REQ-020 EMIT: y_valid SHALL equal ~e; e=1 pauses frame, y_valid=0, pend/count held; e=0 resumes same code.
REQ-021 Handshake: transfer when y_valid=1 and y_ready=1 at a rising edge; SHALL clear served bit of pend and increment count.
REQ-022 y and y_valid SHALL stay stable while y_valid=1 and y_ready=0.
REQ-023 Transfer of the last set bit SHALL move to DONE; done=1, busy=1, y_valid=0 for exactly one cycle, then IDLE.
REQ-024 count SHALL hold its final value in IDLE until next accepted capture; max 16, no wrap.
REQ-025 Back-to-back transfers SHALL sustain one code per cycle while y_ready=1 and e=0.
REQ-026 y SHALL be 4'd0 whenever y_valid=0.

Reset
REQ-027 rst=1 SHALL asynchronously force IDLE, pend=0, count=0, y=0, y_valid=0, busy=0, done=0, zero=0.
REQ-028 rst asserted mid-frame SHALL abandon the frame without done pulse; first edge after rst release with load=1, e=0 SHALL capture normally.

Verification
REQ-029 LSB_FIRST=1, w=16'h8421, load, e=0, y_ready=1 -> y sequence 0,5,10,15 on consecutive cycles, then done pulse, count=4.
REQ-030 LSB_FIRST=0, w=16'h8421 -> y sequence 15,10,5,0; w=16'hFFFF -> 16 codes 15..0, count=16, one done pulse.
REQ-031 w=16'h0000 load, e=0 -> zero pulse one cycle, busy stays 0, count=0, no y_valid.
REQ-032 w=16'h0012, y_ready low 3 cycles then high -> y=1 held stable 3 cycles, then 1,4 accepted; e=1 inserted mid-frame -> y_valid=0, resumes same code.
REQ-033 load with e=1 -> ignored; load while busy with new w -> ignored, original frame completes unchanged.
REQ-034 rst pulse after first code of w=16'h00F0 -> all outputs 0 immediately, no done; new load w=16'h0001 -> y=0, done, count=1.

Source files
------------

// File: rtl/encoder16to4_seq_low_enable.sv
// Sequential 16-to-4 encoder: captures a multi-hot request vector and emits the
// index of each set bit in priority order over a valid/ready handshake.
module encoder16to4_seq_low_enable #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        e,
    input  logic        load,
    input  logic [15:0] w,
    input  logic        y_ready,
    output logic [3:0]  y,
    output logic        y_valid,
    output logic        busy,
    output logic        done,
    output logic        zero,
    output logic [4:0]  count
);
    typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] pend_q, pend_d;
    logic [4:0]  count_q, count_d;
    logic        zero_q, zero_d;
    logic [3:0]  idx;
    logic        xfer;

    // Last match wins, so the scan direction selects the priority end.
    always_comb begin
        idx = 4'd0;
        if (LSB_FIRST) begin
            for (int i = 15; i >= 0; i--)
                if (pend_q[i]) idx = 4'(i);
        end else begin
            for (int i = 0; i < 16; i++)
                if (pend_q[i]) idx = 4'(i);
        end
    end

    assign y_valid = (state_q == EMIT) && !e;
    assign y       = y_valid ? idx : 4'd0;
    assign xfer    = y_valid && y_ready;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign zero    = zero_q;
    assign count   = count_q;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        count_d = count_q;
        zero_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (load && !e) begin
                    pend_d  = w;
                    count_d = 5'd0;
                    if (w == 16'd0) zero_d  = 1'b1;
                    else            state_d = EMIT;
                end
            end
            EMIT: begin
                if (xfer) begin
                    pend_d  = pend_q & ~(16'd1 << idx);
                    count_d = count_q + 5'd1;
                    if (pend_d == 16'd0) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= 16'd0;
            count_q <= 5'd0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            count_q <= count_d;
            zero_q  <= zero_d;
        end
    end
endmodule
